// File: rtl/password_game_pkg.sv
// Shared types and helpers for the password game: FSM states, LFSR taps,
// per-level time budget and binary-to-BCD conversion.
package password_game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    CHECK,
    ADVANCE,
    WIN,
    FAIL
  } state_t;

  // Galois feedback for taps 16,14,13,11 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [6:0] start_secs(input logic [3:0] lvl,
                                            input int unsigned startSecs,
                                            input int unsigned levelDec,
                                            input int unsigned minSecs);
    int budget;
    budget = int'(startSecs) - int'(lvl) * int'(levelDec);
    if (budget < int'(minSecs)) budget = int'(minSecs);
    return 7'(budget);
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] secs);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(secs / 7'd10);
    ones = 4'(secs % 7'd10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/password_game_core_bcd_countdown.sv
// Two-digit BCD down-counter with load; stops at 00.
module bcd_countdown (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       en,
  input  logic       tick,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       hit_zero
);

  logic step;

  assign step = en & tick & ((tens != 4'd0) | (ones != 4'd0));

  // Same-cycle flag so the owner can react to the expiring tick without a cycle of lag
  assign hit_zero = en & tick & (tens == 4'd0) & (ones == 4'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (load) begin
      tens <= load_tens;
      ones <= load_ones;
    end else if (step) begin
      if (ones == 4'd0) begin
        tens <= tens - 4'd1;
        ones <= 4'd9;
      end else begin
        ones <= ones - 4'd1;
      end
    end
  end

endmodule

// File: rtl/password_game_core.sv
// Password game core: FSM, LFSR password source, guess checker with match
// mask/popcount, limited tries and a shrinking per-level countdown.
module password_game_core
  import password_game_pkg::*;
#(
  parameter int unsigned SW_WIDTH   = 10,
  parameter int unsigned NUM_LEVELS = 4,
  parameter int unsigned MAX_TRIES  = 3,
  parameter int unsigned START_SECS = 30,
  parameter int unsigned LEVEL_DEC  = 5,
  parameter int unsigned MIN_SECS   = 10,
  parameter logic [15:0] SEED       = 16'hACE1,
  localparam int unsigned CNT_W     = $clog2(SW_WIDTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                enter,
  input  logic [SW_WIDTH-1:0] guess,
  input  logic                sec_tick,
  output logic [SW_WIDTH-1:0] password,
  output logic [SW_WIDTH-1:0] match_mask,
  output logic [CNT_W-1:0]    match_count,
  output logic [3:0]          level,
  output logic [3:0]          tries_left,
  output logic [3:0]          time_tens,
  output logic [3:0]          time_ones,
  output logic                win,
  output logic                fail
);

  if (SW_WIDTH > 16 || SW_WIDTH < 1) begin : gBadWidth
    $error("password_game_core: SW_WIDTH must be 1..16");
  end
  if (START_SECS > 99) begin : gBadSecs
    $error("password_game_core: START_SECS must be <= 99");
  end
  if (SEED == 16'h0000) begin : gBadSeed
    $error("password_game_core: SEED must be nonzero");
  end

  localparam logic [3:0] LAST_LEVEL = 4'(NUM_LEVELS - 1);
  localparam logic [3:0] TRIES_INIT = 4'(MAX_TRIES);

  state_t                state;
  state_t                stateNext;
  logic [15:0]           lfsr;
  logic [15:0]           lfsrNext;
  logic                  enterQ;
  logic                  enterEdge;
  logic [SW_WIDTH-1:0]   guessQ;
  logic [SW_WIDTH-1:0]   guessNext;
  logic [SW_WIDTH-1:0]   passwordNext;
  logic [SW_WIDTH-1:0]   maskNext;
  logic [SW_WIDTH-1:0]   diffMask;
  logic [CNT_W-1:0]      countNext;
  logic [3:0]            levelNext;
  logic [3:0]            triesNext;
  logic                  winNext;
  logic                  failNext;
  logic                  timerLoad;
  logic                  timerExpire;
  logic [7:0]            budgetBcd;

  assign lfsrNext  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  assign enterEdge = enter & ~enterQ;
  assign diffMask  = ~(guessQ ^ password);
  assign timerLoad = (state == LOAD);
  assign budgetBcd = to_bcd(start_secs(level, START_SECS, LEVEL_DEC, MIN_SECS));

  bcd_countdown uTimer (
    .clk       (clk),
    .reset     (reset),
    .load      (timerLoad),
    .load_tens (budgetBcd[7:4]),
    .load_ones (budgetBcd[3:0]),
    .en        (state == PLAY),
    .tick      (sec_tick),
    .tens      (time_tens),
    .ones      (time_ones),
    .hit_zero  (timerExpire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next state and next values of every game register; hold by default
  always_comb begin
    stateNext    = state;
    guessNext    = guessQ;
    passwordNext = password;
    maskNext     = match_mask;
    countNext    = match_count;
    levelNext    = level;
    triesNext    = tries_left;
    winNext      = win;
    failNext     = fail;
    case (state)
      IDLE, WIN, FAIL: begin
        if (start) begin
          stateNext = LOAD;
          levelNext = 4'd0;
          winNext   = 1'b0;
          failNext  = 1'b0;
        end
      end
      LOAD: begin
        passwordNext = lfsr[SW_WIDTH-1:0];
        triesNext    = TRIES_INIT;
        maskNext     = '0;
        countNext    = '0;
        stateNext    = PLAY;
      end
      PLAY: begin
        // An expiring tick beats a same-cycle guess
        if (timerExpire) begin
          stateNext = FAIL;
          failNext  = 1'b1;
        end else if (enterEdge) begin
          guessNext = guess;
          stateNext = CHECK;
        end
      end
      CHECK: begin
        maskNext  = diffMask;
        countNext = CNT_W'($countones(diffMask));
        if (&diffMask) begin
          stateNext = ADVANCE;
        end else begin
          triesNext = tries_left - 4'd1;
          if (triesNext == 4'd0) begin
            stateNext = FAIL;
            failNext  = 1'b1;
          end else begin
            stateNext = PLAY;
          end
        end
      end
      ADVANCE: begin
        if (level == LAST_LEVEL) begin
          stateNext = WIN;
          winNext   = 1'b1;
        end else begin
          levelNext = level + 4'd1;
          stateNext = LOAD;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr        <= SEED;
      enterQ      <= 1'b0;
      guessQ      <= '0;
      password    <= '0;
      match_mask  <= '0;
      match_count <= '0;
      level       <= 4'd0;
      tries_left  <= 4'd0;
      win         <= 1'b0;
      fail        <= 1'b0;
    end else begin
      lfsr        <= lfsrNext;
      enterQ      <= enter;
      guessQ      <= guessNext;
      password    <= passwordNext;
      match_mask  <= maskNext;
      match_count <= countNext;
      level       <= levelNext;
      tries_left  <= triesNext;
      win         <= winNext;
      fail        <= failNext;
    end
  end

endmodule

// File: tb/tb_password_game_core.sv
// Randomized scenario bench for password_game_core against a game-rules model.
module tb_password_game_core;

  localparam int unsigned SW = 10;
  localparam int unsigned CW = $clog2(SW + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          enter;
  logic          sec_tick;
  logic [SW-1:0] guess;
  logic [SW-1:0] password;
  logic [SW-1:0] match_mask;
  logic [CW-1:0] match_count;
  logic [3:0]    level;
  logic [3:0]    tries_left;
  logic [3:0]    time_tens;
  logic [3:0]    time_ones;
  logic          win;
  logic          fail;
  logic [17:0]   status;

  int vectors     = 0;
  int miscompares = 0;
  int nCyc;

  int            eLevel;
  int            eTries;
  int            eSecs;
  logic          eWin;
  logic          eFail;
  logic [SW-1:0] ePwd;
  logic [SW-1:0] eMask;

  password_game_core #(
    .SW_WIDTH(10), .NUM_LEVELS(4), .MAX_TRIES(3), .START_SECS(30),
    .LEVEL_DEC(5), .MIN_SECS(10), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .enter(enter), .guess(guess),
    .sec_tick(sec_tick), .password(password), .match_mask(match_mask),
    .match_count(match_count), .level(level), .tries_left(tries_left),
    .time_tens(time_tens), .time_ones(time_ones), .win(win), .fail(fail)
  );

  always #5 clk = ~clk;

  assign status = {level, tries_left, time_tens, time_ones, win, fail};

  // Clock edges seen since reset was released
  always @(posedge clk or posedge reset) begin
    if (reset) nCyc <= 0;
    else       nCyc <= nCyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1);
  end

  function automatic logic [15:0] lfsrAfter(input int n);
    logic [15:0] v;
    v = 16'hACE1;
    for (int i = 0; i < n; i++) v = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    return v;
  endfunction

  function automatic int budget(input int lvl);
    int b;
    b = 30 - 5 * lvl;
    return (b < 10) ? 10 : b;
  endfunction

  function automatic logic [7:0] bcd(input int s);
    return {4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int popc(input logic [SW-1:0] x);
    int c;
    c = 0;
    for (int i = 0; i < int'(SW); i++) c += int'(x[i]);
    return c;
  endfunction

  function automatic logic [17:0] expStatus();
    return {4'(eLevel), 4'(eTries), bcd(eSecs), eWin, eFail};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic modelZero();
    eLevel = 0; eTries = 0; eSecs = 0; eWin = 1'b0; eFail = 1'b0;
    ePwd = '0; eMask = '0;
  endtask

  task automatic latchPwd();
    logic [15:0] v;
    v = lfsrAfter(nCyc);
    ePwd = v[SW-1:0];
  endtask

  // Start from IDLE/WIN/FAIL; returns with the game in PLAY
  task automatic startGame();
    start = 1'b1;
    cyc();
    start = 1'b0;
    latchPwd();
    cyc();
    eLevel = 0; eWin = 1'b0; eFail = 1'b0;
    eTries = 3; eSecs = budget(0); eMask = '0;
  endtask

  // One guess from PLAY; runs through CHECK and, on success, the next LOAD
  task automatic submit(input logic [SW-1:0] g);
    guess = g;
    enter = 1'b1;
    cyc();
    enter = 1'b0;
    cyc();
    eMask = ~(g ^ ePwd);
    if (g == ePwd) begin
      cyc();
      if (eLevel == 3) begin
        eWin = 1'b1;
      end else begin
        eLevel++;
        latchPwd();
        cyc();
        eTries = 3; eSecs = budget(eLevel); eMask = '0;
      end
    end else begin
      eTries--;
      if (eTries == 0) eFail = 1'b1;
    end
  endtask

  task automatic tickSec();
    sec_tick = 1'b1;
    cyc();
    sec_tick = 1'b0;
    if (eSecs > 0) begin
      eSecs--;
      if (eSecs == 0) eFail = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; enter = 1'b0; sec_tick = 1'b0; guess = '0;
    modelZero();
    repeat (3) cyc();
    if (status !== expStatus()) begin
      miscompares++; $display("FAIL reset_status: got %h want %h", status, expStatus());
    end
    vectors++;
    if ({password, match_mask, match_count} !== '0) begin
      miscompares++; $display("FAIL reset_data: got %h want 0", {password, match_mask, match_count});
    end
    vectors++;
    reset = 1'b0;
    cyc();
    startGame();
    if (password !== ePwd) begin
      miscompares++; $display("FAIL first_password: got %h want %h", password, ePwd);
    end
    vectors++;
    if (status !== expStatus()) begin
      miscompares++; $display("FAIL first_load: got %h want %h", status, expStatus());
    end
    vectors++;
    submit(ePwd);
    submit(ePwd);
    tickSec();
    if (status !== expStatus()) begin
      miscompares++; $display("FAIL level2_status: got %h want %h", status, expStatus());
    end
    vectors++;
    #2;
    reset = 1'b1;
    #1;
    modelZero();
    if ({status, password, match_mask} !== {expStatus(), ePwd, eMask}) begin
      miscompares++; $display("FAIL async_reset: got %h want %h", {status, password, match_mask}, {expStatus(), ePwd, eMask});
    end
    vectors++;
    cyc();
    reset = 1'b0;
    cyc();
    if (status !== expStatus()) begin
      miscompares++; $display("FAIL post_reset_idle: got %h want %h", status, expStatus());
    end
    vectors++;
    startGame();
    if ({password, status} !== {ePwd, expStatus()}) begin
      miscompares++; $display("FAIL restart_load: got %h want %h", {password, status}, {ePwd, expStatus()});
    end
    vectors++;
  endtask

  task automatic test_wrong_guesses();
    for (int k = 0; k < 3; k++) begin
      logic [SW-1:0] flip;
      flip = SW'($urandom_range(1, 1023));
      submit(ePwd ^ flip);
      if ({match_mask, match_count} !== {eMask, CW'(popc(eMask))}) begin
        miscompares++; $display("FAIL wrong_mask_%0d: got %h/%0d want %h/%0d", k, match_mask, match_count, eMask, popc(eMask));
      end
      vectors++;
      if (status !== expStatus()) begin
        miscompares++; $display("FAIL wrong_status_%0d: got %h want %h", k, status, expStatus());
      end
      vectors++;
    end
  endtask

  task automatic test_levels();
    startGame();
    for (int l = 0; l < 4; l++) begin
      if ({password, status} !== {ePwd, expStatus()}) begin
        miscompares++; $display("FAIL level_load_%0d: got %h want %h", l, {password, status}, {ePwd, expStatus()});
      end
      vectors++;
      repeat ($urandom_range(0, 3)) tickSec();
      submit(ePwd);
    end
    if (status !== expStatus()) begin
      miscompares++; $display("FAIL win_status: got %h want %h", status, expStatus());
    end
    vectors++;
    if (password_game_pkg::start_secs(4'd5, 30, 5, 10) !== 7'(budget(5))) begin
      miscompares++; $display("FAIL budget_clamp: got %0d want %0d", password_game_pkg::start_secs(4'd5, 30, 5, 10), budget(5));
    end
    vectors++;
  endtask

  task automatic test_win_hold();
    logic [SW-1:0] pwdHeld;
    logic [SW-1:0] maskHeld;
    pwdHeld = password;
    maskHeld = match_mask;
    for (int k = 0; k < 6; k++) begin
      guess = SW'($urandom);
      enter = 1'b1;
      sec_tick = 1'($urandom);
      cyc();
      enter = 1'b0;
      sec_tick = 1'b0;
      cyc();
    end
    if ({status, password, match_mask} !== {expStatus(), pwdHeld, maskHeld}) begin
      miscompares++; $display("FAIL win_hold: got %h want %h", {status, password, match_mask}, {expStatus(), pwdHeld, maskHeld});
    end
    vectors++;
    startGame();
    if (status !== expStatus()) begin
      miscompares++; $display("FAIL win_restart: got %h want %h", status, expStatus());
    end
    vectors++;
  endtask

  task automatic test_timeout();
    for (int k = 1; k <= 30; k++) begin
      repeat ($urandom_range(0, 2)) cyc();
      tickSec();
      if (status !== expStatus()) begin
        miscompares++; $display("FAIL timeout_tick_%0d: got %h want %h", k, status, expStatus());
      end
      vectors++;
    end
  endtask

  task automatic test_collision();
    logic [SW-1:0] g;
    startGame();
    g = ePwd ^ SW'($urandom_range(1, 1023));
    guess = g;
    enter = 1'b1;
    cyc();
    enter = 1'b0;
    sec_tick = 1'b1;
    cyc();
    sec_tick = 1'b0;
    eMask = ~(g ^ ePwd);
    eTries--;
    if ({status, match_mask} !== {expStatus(), eMask}) begin
      miscompares++; $display("FAIL tick_in_check: got %h want %h", {status, match_mask}, {expStatus(), eMask});
    end
    vectors++;
    repeat (29) tickSec();
    if (status !== expStatus()) begin
      miscompares++; $display("FAIL timer_at_one: got %h want %h", status, expStatus());
    end
    vectors++;
    guess = ePwd;
    enter = 1'b1;
    sec_tick = 1'b1;
    cyc();
    enter = 1'b0;
    sec_tick = 1'b0;
    eSecs = 0;
    eFail = 1'b1;
    repeat (3) cyc();
    if ({status, match_mask} !== {expStatus(), eMask}) begin
      miscompares++; $display("FAIL expire_vs_enter: got %h want %h", {status, match_mask}, {expStatus(), eMask});
    end
    vectors++;
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] g;
    startGame();
    tickSec();
    start = 1'b1;
    repeat (3) cyc();
    start = 1'b0;
    cyc();
    if ({password, status} !== {ePwd, expStatus()}) begin
      miscompares++; $display("FAIL start_in_play: got %h want %h", {password, status}, {ePwd, expStatus()});
    end
    vectors++;
    g = ePwd ^ SW'($urandom_range(1, 1023));
    guess = g;
    enter = 1'b1;
    repeat (6) cyc();
    enter = 1'b0;
    cyc();
    eMask = ~(g ^ ePwd);
    eTries--;
    if ({status, match_mask, match_count} !== {expStatus(), eMask, CW'(popc(eMask))}) begin
      miscompares++; $display("FAIL enter_held: got %h want %h", {status, match_mask, match_count}, {expStatus(), eMask, CW'(popc(eMask))});
    end
    vectors++;
  endtask

  initial begin
    test_reset();
    test_wrong_guesses();
    test_levels();
    test_win_hold();
    test_timeout();
    test_collision();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
